inst_loader: RTL and testbench
==============================

# inst_loader

Boot-time instruction loader: the write side of the instruction memory that the arithmetic machine fetches from. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and writes them to consecutive word addresses starting at 0. The machine's `reset` is held asserted until the load completes, then released.

## Interface
Parameters:
- `ADDR_W`, default 10: word-address width. Memory depth is 2^ADDR_W words. `mem_addr` corresponds to `PC[ADDR_W+1:2]`.

Ports:
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a load; sampled only in IDLE, DONE or ERROR.
- `num_words`  in  ADDR_W+1  number of words to load; latched when `start` is accepted.
- `byte_in`  in  8  stream data.
- `byte_valid`  in  1  `byte_in` holds a valid byte.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `mem_wr_en`  out  1  one-cycle write strobe to instruction memory.
- `mem_addr`  out  ADDR_W  word address of the write.
- `mem_wr_data`  out  32  instruction word to write.
- `cpu_reset`  out  1  drives the machine's `reset`; high except in DONE.
- `done`  out  1  load completed successfully.
- `error`  out  1  checksum mismatch; only driven when `LOADER_CHECKSUM_EN` is defined, else tied 0.

## Operation
- States: IDLE, RECV, WRITE, CHECK (only with the macro), DONE, ERROR. All outputs are registered, or decoded from the state register only (Moore).
- IDLE: `byte_ready`=0 and `cpu_reset`=1.
  - `start` with `num_words`≠0 → RECV. Latch the count, clear the address, byte index and checksum.
  - `start` with `num_words`=0 → DONE. No writes occur.
- RECV: `byte_ready`=1.
  - A byte transfers only when `byte_valid`&`byte_ready` are both high.
  - Byte k (k=0..3) fills `mem_wr_data[8k+7:8k]`.
  - The 4th byte → WRITE.
  - With `byte_valid` low, state is held indefinitely.
- WRITE: `byte_ready`=0. Assert `mem_wr_en` for exactly one cycle with `mem_addr` and `mem_wr_data` stable.
  - Next cycle: if this was the last word → CHECK (macro) or DONE.
  - Otherwise → RECV, with `mem_addr` incremented by 1.
- DONE: `done`=1 and `cpu_reset`=0.
  - `start` re-arms the load identically to IDLE. `cpu_reset` returns to 1 in the cycle after `start` is accepted.
- ERROR: `error`=1 and `cpu_reset`=1. Exit only via `start` or `reset`.
- `start` is ignored in RECV, WRITE and CHECK.
- Address arithmetic: `mem_addr` wraps modulo 2^ADDR_W. `num_words`=2^ADDR_W writes every location exactly once. `num_words` above 2^ADDR_W is saturated to 2^ADDR_W at latch time.
- Reset asserted at any time, including mid-word: return to IDLE immediately with all outputs at their reset values. A partially assembled word is discarded and never written.

## Timing
- Reset values:
  - `byte_ready`=0, `mem_wr_en`=0, `mem_addr`=0, `mem_wr_data`=0.
  - `cpu_reset`=1, `done`=0, `error`=0.
- `start` accepted at edge t → RECV (`byte_ready`=1) from cycle t+1.
- Byte transfers occur on rising edges where `byte_valid`&`byte_ready`=1.
- 4th byte of a word accepted at edge t → `mem_wr_en`=1 during cycle t+1 → `byte_ready`=1 again at t+2.
- Peak throughput: 5 cycles per word.
- Last write at cycle t → `done`=1 and `cpu_reset`=0 at t+1 (no macro), or at t+2 (macro, after CHECK).

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - Maintain a running 8-bit XOR of all data bytes.
  - After the last WRITE, enter CHECK with `byte_ready`=1 and accept exactly one checksum byte.
  - Checksum byte equals the running XOR → DONE; otherwise → ERROR.
- Not defined: CHECK and ERROR do not exist, `error` is constant 0, and the last WRITE goes directly to DONE.

## Test plan
- Reset, `start` with `num_words`=2, continuous bytes 78 56 34 12 EF BE AD DE → exactly two writes: addr0=0x12345678, addr1=0xDEADBEEF, each `mem_wr_en` one cycle wide. `done`=1 and `cpu_reset`=0 one cycle after the second write.
- Same load with `byte_valid` low for 3 cycles between every byte → identical writes. No transfer occurs while `byte_valid` is low.
- `start` with `num_words`=0 → DONE on the next cycle, `mem_wr_en` never asserted.
- Assert `reset` after 2 bytes of word 0 → all outputs at reset values next edge, no write. Subsequent `start` with `num_words`=1 and bytes 01 00 00 00 → addr0=0x00000001.
- `LOADER_CHECKSUM_EN`, `num_words`=1, bytes 11 22 44 88:
  - checksum FF → DONE;
  - checksum 00 → `error`=1, `cpu_reset`=1, `done`=0.
- From DONE, `start` with `num_words`=1 → `cpu_reset`=1 the next cycle, reload writes addr0, then returns to DONE.

Source files
------------

// File: rtl/inst_loader.sv
// Boot-time instruction loader: assembles little-endian words from a byte stream and writes them
// to instruction memory from address 0. Optional checksum stage enabled by LOADER_CHECKSUM_EN.
module inst_loader #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wr_data,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    StIdle,
    StRecv,
    StWrite,
`ifdef LOADER_CHECKSUM_EN
    StCheck,
    StError,
`endif
    StDone
  } state_e;

  localparam logic [ADDR_W:0] MaxWords = {1'b1, {ADDR_W{1'b0}}};

  state_e          state;
  logic [ADDR_W:0] words_left;
  logic [1:0]      byte_idx;
  logic            start_ok;
  logic [ADDR_W:0] words_sat;
  logic            byte_xfer;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;
`endif

  assign words_sat = (num_words > MaxWords) ? MaxWords : num_words;
  assign byte_xfer = byte_valid && byte_ready;

  always_comb begin
    start_ok = start && (state == StIdle || state == StDone);
`ifdef LOADER_CHECKSUM_EN
    if (start && state == StError) start_ok = 1'b1;
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= StIdle;
      words_left  <= '0;
      byte_idx    <= '0;
      byte_ready  <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      cpu_reset   <= 1'b1;
      done        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum        <= '0;
      error       <= 1'b0;
`endif
    end else if (start_ok) begin
      words_left <= words_sat;
      mem_addr   <= '0;
      byte_idx   <= '0;
      mem_wr_en  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum       <= '0;
      error      <= 1'b0;
`endif
      if (num_words == '0) begin
        state      <= StDone;
        byte_ready <= 1'b0;
        cpu_reset  <= 1'b0;
        done       <= 1'b1;
      end else begin
        state      <= StRecv;
        byte_ready <= 1'b1;
        cpu_reset  <= 1'b1;
        done       <= 1'b0;
      end
    end else begin
      case (state)
        StRecv: begin
          if (byte_xfer) begin
            // Bytes land directly in the write-data register; it is only strobed once complete.
            mem_wr_data[{byte_idx, 3'b000} +: 8] <= byte_in;
            byte_idx <= byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            csum <= csum ^ byte_in;
`endif
            if (byte_idx == 2'd3) begin
              state      <= StWrite;
              byte_ready <= 1'b0;
              mem_wr_en  <= 1'b1;
            end
          end
        end
        StWrite: begin
          mem_wr_en <= 1'b0;
          if (words_left == (ADDR_W+1)'(1)) begin
`ifdef LOADER_CHECKSUM_EN
            state      <= StCheck;
            byte_ready <= 1'b1;
`else
            state     <= StDone;
            done      <= 1'b1;
            cpu_reset <= 1'b0;
`endif
          end else begin
            words_left <= words_left - (ADDR_W+1)'(1);
            mem_addr   <= mem_addr + ADDR_W'(1);
            state      <= StRecv;
            byte_ready <= 1'b1;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        StCheck: begin
          if (byte_xfer) begin
            byte_ready <= 1'b0;
            if (byte_in == csum) begin
              state     <= StDone;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
            end else begin
              state <= StError;
              error <= 1'b1;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

`ifndef LOADER_CHECKSUM_EN
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: table of load vectors plus hand-written reset/checksum sequences.
module tb_inst_loader;

  localparam int unsigned AW = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   num_words = '0;
  logic [7:0]    byte_in = '0;
  logic          byte_valid = 1'b0;
  logic          byte_ready;
  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wr_data;
  logic          cpu_reset;
  logic          done;
  logic          error;

  inst_loader #(.ADDR_W(AW)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .num_words  (num_words),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .mem_wr_en  (mem_wr_en),
    .mem_addr   (mem_addr),
    .mem_wr_data(mem_wr_data),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Monitor: owns all observation state, sampled at the rising edge (pre-update values).
  int            cyc = 0;
  logic [AW-1:0] wr_addr_q[$];
  logic [31:0]   wr_data_q[$];
  int            last_wr_cyc = -1;
  int            done_rise_cyc = -1;
  int            wide_pulses = 0;
  int            ready_in_write = 0;
  int            xfers = 0;
  logic          wr_prev = 1'b0;
  logic          done_prev = 1'b0;

  always @(posedge clock) begin
    cyc = cyc + 1;
    if (mem_wr_en) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wr_data);
      last_wr_cyc = cyc;
      if (wr_prev) wide_pulses = wide_pulses + 1;
      if (byte_ready) ready_in_write = ready_in_write + 1;
    end
    if (done && !done_prev) done_rise_cyc = cyc;
    if (byte_valid && byte_ready) xfers = xfers + 1;
    wr_prev = mem_wr_en;
    done_prev = done;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [AW:0]  nw;
    logic [3:0]   gap;
    logic [4:0]   nbytes;
    logic [127:0] bytes;  // byte k at [8k+7:8k]
    logic [2:0]   nexp;
    logic [127:0] words;  // expected word i at [32i+31:32i]
    logic [7:0]   mask;   // xored onto the sent checksum
  } vec_t;

  task automatic run_vec(input vec_t v, input string tag);
    int base_wr, base_wide, base_rdy, base_x, nb, idx, gapcnt, guard;
    logic [7:0] ck;
    base_wr = wr_data_q.size();
    base_wide = wide_pulses;
    base_rdy = ready_in_write;
    base_x = xfers;
    @(negedge clock);
    start = 1'b1;
    num_words = v.nw;
    @(posedge clock);
    #1 start = 1'b0;
    chk({tag, "_err_clr"}, 32'(error), 32'd0);
    if (v.nw == '0) begin
      chk({tag, "_zero_done"}, 32'(done), 32'd1);
      chk({tag, "_zero_cpu_rst"}, 32'(cpu_reset), 32'd0);
      repeat (4) @(negedge clock);
      chk({tag, "_zero_writes"}, 32'(wr_data_q.size() - base_wr), 32'd0);
      return;
    end
    chk({tag, "_ready"}, 32'(byte_ready), 32'd1);
    chk({tag, "_cpu_rst"}, 32'(cpu_reset), 32'd1);
    chk({tag, "_done_lo"}, 32'(done), 32'd0);
    ck = '0;
    for (int k = 0; k < int'(v.nbytes); k++) ck = ck ^ v.bytes[8*k +: 8];
    nb = int'(v.nbytes);
`ifdef LOADER_CHECKSUM_EN
    nb = nb + 1;
`endif
    idx = 0;
    gapcnt = 0;
    guard = 0;
    while (idx < nb && guard < 2000) begin
      @(negedge clock);
      guard++;
      if (byte_ready && gapcnt >= int'(v.gap)) begin
        byte_valid = 1'b1;
        byte_in = (idx < int'(v.nbytes)) ? v.bytes[8*idx +: 8] : (ck ^ v.mask);
        idx++;
        gapcnt = 0;
      end else begin
        byte_valid = 1'b0;
        byte_in = 8'h00;
        if (byte_ready) gapcnt++;
      end
    end
    @(negedge clock);
    byte_valid = 1'b0;
    guard = 0;
    while (!(done || error) && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    chk({tag, "_finish_in_time"}, 32'(guard < 200), 32'd1);
    @(posedge clock);
    #1;
    chk({tag, "_nwrites"}, 32'(wr_data_q.size() - base_wr), 32'(v.nexp));
    for (int i = 0; i < int'(v.nexp) && base_wr + i < wr_data_q.size(); i++) begin
      chk({tag, "_addr"}, 32'(wr_addr_q[base_wr + i]), 32'(i % (1 << AW)));
      chk({tag, "_data"}, wr_data_q[base_wr + i], v.words[32*i +: 32]);
    end
    chk({tag, "_pulse_1cyc"}, 32'(wide_pulses - base_wide), 32'd0);
    chk({tag, "_noready_in_wr"}, 32'(ready_in_write - base_rdy), 32'd0);
    chk({tag, "_xfers"}, 32'(xfers - base_x), 32'(nb));
`ifdef LOADER_CHECKSUM_EN
    if (v.mask != 8'h00) begin
      chk({tag, "_error"}, 32'(error), 32'd1);
      chk({tag, "_err_cpu_rst"}, 32'(cpu_reset), 32'd1);
      chk({tag, "_err_done"}, 32'(done), 32'd0);
    end else begin
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_cpu_rst_lo"}, 32'(cpu_reset), 32'd0);
      chk({tag, "_done_after_wr"}, 32'(done_rise_cyc > last_wr_cyc), 32'd1);
    end
`else
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_cpu_rst_lo"}, 32'(cpu_reset), 32'd0);
    chk({tag, "_done_latency"}, 32'(done_rise_cyc - last_wr_cyc), 32'd1);
`endif
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    chk({tag, "_wr_en"}, 32'(mem_wr_en), 32'd0);
    chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_wr_data"}, mem_wr_data, 32'd0);
    chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
  endtask

  vec_t vecs[6];
  vec_t tail;
  int   base_wr;

  initial begin
    vecs[0] = '{nw: 3'd2, gap: 4'd0, nbytes: 5'd8,
                bytes: {8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78},
                nexp: 3'd2, words: {32'hDEADBEEF, 32'h12345678}, mask: 8'h00};
    vecs[1] = vecs[0];
    vecs[1].gap = 4'd3;
    vecs[2] = '{nw: 3'd0, gap: 4'd0, nbytes: 5'd0, bytes: '0, nexp: 3'd0, words: '0,
                mask: 8'h00};
    // Count above the memory depth saturates: every location written exactly once.
    vecs[3] = '{nw: 3'd7, gap: 4'd0, nbytes: 5'd16,
                bytes: 128'h0F0E0D0C_0B0A0908_07060504_03020100,
                nexp: 3'd4,
                words: {32'h0F0E0D0C, 32'h0B0A0908, 32'h07060504, 32'h03020100},
                mask: 8'h00};
    vecs[4] = '{nw: 3'd1, gap: 4'd1, nbytes: 5'd4,
                bytes: {96'h0, 8'h88, 8'h44, 8'h22, 8'h11},
                nexp: 3'd1, words: {96'h0, 32'h88442211}, mask: 8'h00};
    // Sends checksum 00 instead of FF when the checksum stage exists.
    vecs[5] = vecs[4];
    vecs[5].mask = 8'hFF;
    tail = '{nw: 3'd1, gap: 4'd0, nbytes: 5'd4, bytes: {96'h0, 8'h00, 8'h00, 8'h00, 8'h01},
             nexp: 3'd1, words: {96'h0, 32'h00000001}, mask: 8'h00};

    repeat (3) @(negedge clock);
    chk_reset_vals("rst");
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Reset in the middle of a word: partial word discarded.
    base_wr = wr_data_q.size();
    @(negedge clock);
    start = 1'b1;
    num_words = 3'd1;
    @(posedge clock);
    #1 start = 1'b0;
    @(negedge clock);
    byte_valid = 1'b1;
    byte_in = 8'hAA;
    @(negedge clock);
    byte_in = 8'hBB;
    @(negedge clock);
    byte_valid = 1'b0;
    #2 reset = 1'b1;
    #1 chk_reset_vals("midrst");
    @(negedge clock);
    reset = 1'b0;
    repeat (6) @(negedge clock);
    chk("midrst_no_write", 32'(wr_data_q.size() - base_wr), 32'd0);
    run_vec(tail, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
